// File: rtl/imm_buffer_pkg.sv
// Shared types and sizing helpers for the immediate buffer: FSM encoding and
// derived widths of the immediate and of the serial position counter.
package imm_buffer_pkg;

    localparam int IMMB_REG_BITS = 8;
    localparam int IMMB_NSHIFT   = 2;

    typedef enum logic [1:0] {
        IMMB_IDLE    = 2'd0,
        IMMB_LOAD_HI = 2'd1,
        IMMB_FULL    = 2'd2
    } immb_state_e;

    function automatic int imm_bits(input int reg_bits);
        return 2 * reg_bits;
    endfunction

    // Counter must be at least one bit wide even if a single shift covers the word.
    function automatic int sc_width(input int reg_bits, input int nshift);
        int w;
        w = $clog2((2 * reg_bits) / nshift);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int IMM_BITS = imm_bits(IMMB_REG_BITS);
    localparam int SC_W     = sc_width(IMMB_REG_BITS, IMMB_NSHIFT);

endpackage

// File: rtl/imm_buffer_if.sv
// Bundles the scheduler, decoder and prefetch-queue signals seen by imm_buffer.
// The slave modport is the buffer itself; master is whoever drives it.
interface imm_buffer_if #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) ();
    import imm_buffer_pkg::*;

    localparam int SCW = sc_width(REG_BITS, NSHIFT);

    logic                inst_done;
    logic                load_imm16;
    logic                imm16_loaded;
    logic                imm8_load;
    logic [REG_BITS-1:0] imm8_value;
    logic                imm8_sext;
    logic                q_byte_valid;
    logic [REG_BITS-1:0] q_byte;
    logic                q_byte_pop;
    logic                next_imm_data;
    logic [NSHIFT-1:0]   imm_data_out;
    logic [NSHIFT-1:0]   imm_wb_in;
    logic [SCW-1:0]      shift_count;

    modport slave (
        input  inst_done, load_imm16, imm8_load, imm8_value, imm8_sext,
               q_byte_valid, q_byte, next_imm_data, imm_wb_in,
        output imm16_loaded, q_byte_pop, imm_data_out, shift_count
    );

    modport master (
        output inst_done, load_imm16, imm8_load, imm8_value, imm8_sext,
               q_byte_valid, q_byte, next_imm_data, imm_wb_in,
        input  imm16_loaded, q_byte_pop, imm_data_out, shift_count
    );

endinterface

// File: rtl/imm_buffer_shreg.sv
// Immediate storage with byte-wise parallel load and an NSHIFT-wide serial
// shift that pulls write-back bits into the top, plus the serial position count.
module imm_shift_reg
    import imm_buffer_pkg::*;
#(
    parameter  int REG_BITS = 8,
    parameter  int NSHIFT   = 2,
    localparam int IMM      = 2 * REG_BITS,
    localparam int SCW      = sc_width(REG_BITS, NSHIFT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_lo_i,
    input  logic                load_hi_i,
    input  logic                load_all_i,
    input  logic [REG_BITS-1:0] byte_i,
    input  logic [IMM-1:0]      word_i,
    input  logic                shift_i,
    input  logic [NSHIFT-1:0]   wb_i,
    input  logic                clr_count_i,
    output logic [IMM-1:0]      imm_o,
    output logic [SCW-1:0]      count_o
);

    localparam logic [SCW-1:0] COUNT_LAST = SCW'(IMM / NSHIFT - 1);

    logic [IMM-1:0] imm_q, imm_d;
    logic [SCW-1:0] count_q, count_d;

    always_comb begin
        imm_d = imm_q;
        if (load_all_i) begin
            imm_d = word_i;
        end else if (load_lo_i) begin
            imm_d[REG_BITS-1:0] = byte_i;
        end else if (load_hi_i) begin
            imm_d[IMM-1:REG_BITS] = byte_i;
        end else if (shift_i) begin
            imm_d = {wb_i, imm_q[IMM-1:NSHIFT]};
        end
    end

    // Explicit wrap so non-power-of-two lane counts still cycle correctly.
    always_comb begin
        count_d = count_q;
        if (clr_count_i) begin
            count_d = '0;
        end else if (shift_i) begin
            count_d = (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imm_q   <= '0;
            count_q <= '0;
        end else begin
            imm_q   <= imm_d;
            count_q <= count_d;
        end
    end

    assign imm_o   = imm_q;
    assign count_o = count_q;

endmodule

// File: rtl/imm_buffer.sv
// Immediate operand buffer: assembles a 16-bit immediate from the prefetch
// queue or an extended imm8, then streams it NSHIFT bits per cycle.
module imm_buffer
    import imm_buffer_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input logic          clk,
    input logic          reset_n,
    imm_buffer_if.slave  bus
);

    localparam int IMM = 2 * REG_BITS;
    localparam int SCW = sc_width(REG_BITS, NSHIFT);

    immb_state_e    state_q, state_d;
    logic           loaded_q, loaded_d;
    logic           pop;
    logic           load_lo, load_hi, load_all, shift_en, clr_count;
    logic [IMM-1:0] imm8_word;
    logic [IMM-1:0] imm_cur;
    logic [SCW-1:0] count_cur;

    assign imm8_word = {{REG_BITS{bus.imm8_sext & bus.imm8_value[REG_BITS-1]}},
                        bus.imm8_value};

    always_comb begin
        state_d   = state_q;
        loaded_d  = 1'b0;
        pop       = 1'b0;
        load_lo   = 1'b0;
        load_hi   = 1'b0;
        load_all  = 1'b0;
        shift_en  = 1'b0;
        clr_count = 1'b0;
        if (bus.inst_done) begin
            state_d   = IMMB_IDLE;
            clr_count = 1'b1;
        end else begin
            case (state_q)
                IMMB_IDLE: begin
                    // A pending 16-bit request blocks imm8 even while the queue is empty.
                    if (bus.load_imm16) begin
                        if (bus.q_byte_valid) begin
                            pop     = 1'b1;
                            load_lo = 1'b1;
                            state_d = IMMB_LOAD_HI;
                        end
                    end else if (bus.imm8_load) begin
                        load_all = 1'b1;
                        state_d  = IMMB_FULL;
                    end
                end
                IMMB_LOAD_HI: begin
                    if (bus.q_byte_valid) begin
                        pop      = 1'b1;
                        load_hi  = 1'b1;
                        loaded_d = 1'b1;
                        state_d  = IMMB_FULL;
                    end
                end
                IMMB_FULL: begin
                    shift_en = bus.next_imm_data;
                end
                default: begin
                    state_d = IMMB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IMMB_IDLE;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
        end
    end

    imm_shift_reg #(
        .REG_BITS (REG_BITS),
        .NSHIFT   (NSHIFT)
    ) u_shreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_lo_i   (load_lo),
        .load_hi_i   (load_hi),
        .load_all_i  (load_all),
        .byte_i      (bus.q_byte),
        .word_i      (imm8_word),
        .shift_i     (shift_en),
        .wb_i        (bus.imm_wb_in),
        .clr_count_i (clr_count),
        .imm_o       (imm_cur),
        .count_o     (count_cur)
    );

    // Pop is suppressed while reset is held so an aborted load never consumes a byte.
    assign bus.q_byte_pop   = pop & reset_n;
    assign bus.imm16_loaded = loaded_q;
    assign bus.imm_data_out = imm_cur[NSHIFT-1:0];
    assign bus.shift_count  = count_cur;

endmodule

// File: tb/tb_imm_buffer.sv
// Directed bench for imm_buffer: byte loads, queue stalls, serial wrap,
// imm8 extension, inst_done abort and asynchronous reset mid-stream.
module tb_imm_buffer;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    imm_buffer_if #(.REG_BITS(8), .NSHIFT(2)) bus ();

    imm_buffer #(.REG_BITS(8), .NSHIFT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] ser_exp [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        ser_exp = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

        reset_n           = 1'b0;
        bus.inst_done     = 1'b0;
        bus.load_imm16    = 1'b0;
        bus.imm8_load     = 1'b0;
        bus.imm8_value    = '0;
        bus.imm8_sext     = 1'b0;
        bus.q_byte_valid  = 1'b0;
        bus.q_byte        = '0;
        bus.next_imm_data = 1'b0;
        bus.imm_wb_in     = '0;
        tick();
        tick();
        chk("rst_buf",    32'(dut.u_shreg.imm_q), 32'h0);
        chk("rst_state",  32'(dut.state_q), 32'd0);
        chk("rst_loaded", 32'(bus.imm16_loaded), 32'd0);
        chk("rst_count",  32'(bus.shift_count), 32'd0);
        chk("rst_data",   32'(bus.imm_data_out), 32'd0);
        reset_n = 1'b1;
        tick();

        // Load 0xBEEF, start shifting, then reset asynchronously mid-stream
        bus.load_imm16   = 1'b1;
        bus.q_byte_valid = 1'b1;
        bus.q_byte       = 8'hEF;
        #1 chk("beef_pop_lo", 32'(bus.q_byte_pop), 32'd1);
        tick();
        bus.q_byte = 8'hBE;
        #1 chk("beef_pop_hi", 32'(bus.q_byte_pop), 32'd1);
        tick();
        bus.load_imm16   = 1'b0;
        bus.q_byte_valid = 1'b0;
        chk("beef_buf",    32'(dut.u_shreg.imm_q), 32'hBEEF);
        chk("beef_loaded", 32'(bus.imm16_loaded), 32'd1);
        bus.next_imm_data = 1'b1;
        bus.imm_wb_in     = 2'b11;
        tick();
        chk("beef_count1", 32'(bus.shift_count), 32'd1);
        chk("beef_loaded_drop", 32'(bus.imm16_loaded), 32'd0);
        bus.load_imm16   = 1'b1;
        bus.q_byte_valid = 1'b1;
        #1 chk("full_no_pop", 32'(bus.q_byte_pop), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_buf",   32'(dut.u_shreg.imm_q), 32'h0);
        chk("arst_state", 32'(dut.state_q), 32'd0);
        chk("arst_data",  32'(bus.imm_data_out), 32'd0);
        chk("arst_count", 32'(bus.shift_count), 32'd0);
        chk("arst_pop",   32'(bus.q_byte_pop), 32'd0);
        tick();
        bus.load_imm16    = 1'b0;
        bus.q_byte_valid  = 1'b0;
        bus.next_imm_data = 1'b0;
        reset_n = 1'b1;
        tick();

        // Back-to-back 0x34, 0x12
        bus.load_imm16   = 1'b1;
        bus.q_byte_valid = 1'b1;
        bus.q_byte       = 8'h34;
        #1 chk("b2b_pop_lo", 32'(bus.q_byte_pop), 32'd1);
        tick();
        bus.q_byte = 8'h12;
        chk("b2b_loaded_early", 32'(bus.imm16_loaded), 32'd0);
        #1 chk("b2b_pop_hi", 32'(bus.q_byte_pop), 32'd1);
        tick();
        bus.load_imm16   = 1'b0;
        bus.q_byte_valid = 1'b0;
        chk("b2b_loaded", 32'(bus.imm16_loaded), 32'd1);
        chk("b2b_buf",    32'(dut.u_shreg.imm_q), 32'h1234);
        chk("b2b_state",  32'(dut.state_q), 32'd2);
        tick();
        chk("b2b_pulse_end", 32'(bus.imm16_loaded), 32'd0);

        // Full serial wrap with write-back equal to output
        bus.next_imm_data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_data%0d", i),  32'(bus.imm_data_out), 32'(ser_exp[i]));
            chk($sformatf("ser_count%0d", i), 32'(bus.shift_count), 32'(i));
            bus.imm_wb_in = ser_exp[i];
            tick();
        end
        bus.next_imm_data = 1'b0;
        chk("ser_wrap_count", 32'(bus.shift_count), 32'd0);
        chk("ser_restored",   32'(dut.u_shreg.imm_q), 32'h1234);

        bus.inst_done = 1'b1;
        tick();
        bus.inst_done = 1'b0;
        chk("done_state", 32'(dut.state_q), 32'd0);

        // Load with a 3-cycle empty-queue gap between bytes
        bus.load_imm16   = 1'b1;
        bus.q_byte_valid = 1'b1;
        bus.q_byte       = 8'hAB;
        tick();
        bus.q_byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("gap_pop%0d", i),    32'(bus.q_byte_pop), 32'd0);
            chk($sformatf("gap_state%0d", i),  32'(dut.state_q), 32'd1);
            chk($sformatf("gap_loaded%0d", i), 32'(bus.imm16_loaded), 32'd0);
            tick();
        end
        bus.q_byte_valid = 1'b1;
        bus.q_byte       = 8'hCD;
        #1 chk("gap_pop_hi", 32'(bus.q_byte_pop), 32'd1);
        tick();
        bus.load_imm16   = 1'b0;
        bus.q_byte_valid = 1'b0;
        chk("gap_loaded", 32'(bus.imm16_loaded), 32'd1);
        chk("gap_buf",    32'(dut.u_shreg.imm_q), 32'hCDAB);
        tick();
        chk("gap_pulse_end", 32'(bus.imm16_loaded), 32'd0);
        bus.inst_done = 1'b1;
        tick();
        bus.inst_done = 1'b0;

        // imm8 sign extension
        bus.imm8_load  = 1'b1;
        bus.imm8_value = 8'h80;
        bus.imm8_sext  = 1'b1;
        tick();
        bus.imm8_load = 1'b0;
        chk("sext_buf",    32'(dut.u_shreg.imm_q), 32'hFF80);
        chk("sext_state",  32'(dut.state_q), 32'd2);
        chk("sext_loaded", 32'(bus.imm16_loaded), 32'd0);
        tick();
        chk("sext_loaded2", 32'(bus.imm16_loaded), 32'd0);
        bus.inst_done = 1'b1;
        tick();
        bus.inst_done = 1'b0;

        // imm8 zero extension
        bus.imm8_load = 1'b1;
        bus.imm8_sext = 1'b0;
        tick();
        bus.imm8_load = 1'b0;
        chk("zext_buf",    32'(dut.u_shreg.imm_q), 32'h0080);
        chk("zext_loaded", 32'(bus.imm16_loaded), 32'd0);
        tick();
        chk("zext_loaded2", 32'(bus.imm16_loaded), 32'd0);
        bus.inst_done = 1'b1;
        tick();
        bus.inst_done = 1'b0;

        // inst_done abort in LOAD_HI with a byte available
        bus.load_imm16   = 1'b1;
        bus.q_byte_valid = 1'b1;
        bus.q_byte       = 8'h55;
        tick();
        chk("abort_in_hi", 32'(dut.state_q), 32'd1);
        bus.q_byte    = 8'h66;
        bus.inst_done = 1'b1;
        #1 chk("abort_no_pop", 32'(bus.q_byte_pop), 32'd0);
        tick();
        bus.inst_done    = 1'b0;
        bus.load_imm16   = 1'b0;
        bus.q_byte_valid = 1'b0;
        chk("abort_state",  32'(dut.state_q), 32'd0);
        chk("abort_count",  32'(bus.shift_count), 32'd0);
        chk("abort_buf",    32'(dut.u_shreg.imm_q), 32'h0055);
        chk("abort_loaded", 32'(bus.imm16_loaded), 32'd0);
        bus.next_imm_data = 1'b1;
        bus.imm_wb_in     = 2'b11;
        tick();
        tick();
        bus.next_imm_data = 1'b0;
        chk("idle_shift_buf",   32'(dut.u_shreg.imm_q), 32'h0055);
        chk("idle_shift_count", 32'(bus.shift_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
